// File: rtl/latch_en_sequencer.sv
// latch_en_sequencer
// Drives a transparent latch (D = o_a, gate = o_en) from a valid/ready word
// stream. Each word becomes a setup / gate-open / hold sequence. The Q
// readback is compared at the end of hold: a mismatch raises a sticky error
// flag, and each completed transfer increments a wrapping counter.
module latch_en_sequencer #(
   parameter int WIDTH     = 1,
   parameter int SETUP_CYC = 1,
   parameter int OPEN_CYC  = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_a,
   output logic             o_en,
   input  logic [WIDTH-1:0] i_q,
   output logic             o_busy,
   output logic             o_err,
   input  logic             i_err_clr,
   output logic [15:0]      o_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_OPEN  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   // Phase timer width; the timer is loaded with (cycles - 1) and counts to 0.
   localparam int TW = 16;
   localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
   localparam logic [TW-1:0] OPEN_LD  = TW'(OPEN_CYC - 1);
   localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

   logic [1:0]       state_q, state_d;
   logic [TW-1:0]    tmr_q,   tmr_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic             en_q,    en_d;
   logic             busy_q,  busy_d;
   logic             err_q,   err_d;
   logic [15:0]      cnt_q,   cnt_d;

   logic last_cyc;
   logic accept;
   logic hold_done;

   assign last_cyc  = (tmr_q == '0);
   assign hold_done = (state_q == ST_HOLD) && last_cyc;
   // Ready in the last hold cycle lets the next word start with no idle gap.
   assign o_ready   = (state_q == ST_IDLE) || hold_done;
   assign accept    = i_valid && o_ready;

   assign o_a    = a_q;
   assign o_en   = en_q;
   assign o_busy = busy_q;
   assign o_err  = err_q;
   assign o_cnt  = cnt_q;

   // Next-state logic: sequence phases, data capture, readback check and count.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      a_d     = a_q;
      en_d    = en_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SETUP;
               tmr_d   = SETUP_LD;
               a_d     = i_data;
            end
         end
         ST_SETUP: begin
            if (last_cyc) begin
               state_d = ST_OPEN;
               tmr_d   = OPEN_LD;
               en_d    = 1'b1;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         ST_OPEN: begin
            if (last_cyc) begin
               state_d = ST_HOLD;
               tmr_d   = HOLD_LD;
               en_d    = 1'b0;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         ST_HOLD: begin
            if (last_cyc) begin
               cnt_d = cnt_q + 16'd1;
               if (accept) begin
                  state_d = ST_SETUP;
                  tmr_d   = SETUP_LD;
                  a_d     = i_data;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
         end
      endcase
      // A mismatch on the same edge as a clear request keeps the flag set.
      err_d  = (err_q && !i_err_clr) || (hold_done && (i_q != a_q));
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset closes the gate without waiting for a clock.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         a_q     <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         a_q     <= a_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_latch_en_sequencer.sv
// Bench for latch_en_sequencer: two instances (default timing and 2/3/2
// timing), each fed by a behavioural latch on i_q and checked every cycle
// against a phase-count reference model, plus directed literal checks.
module tb_latch_en_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic vld [2];
   logic dat [2];
   logic clr [2];
   logic fz  [2];
   logic rdy [2];
   logic a   [2];
   logic en  [2];
   logic qv  [2];
   logic busy[2];
   logic err [2];
   logic [15:0] cnt [2];
   logic ql  [2] = '{1'b0, 1'b0};

   int SS[2] = '{1, 2};
   int OO[2] = '{2, 3};
   int HH[2] = '{1, 2};

   int n_pass = 0;
   int n_tot  = 0;
   int viol   = 0;
   bit go     = 1'b0;
   bit mon_on = 1'b1;
   logic [15:0] base[2];

   // reference model state: active transfer, edges since acceptance, data, counters
   bit          act_m[2] = '{1'b0, 1'b0};
   int          t_m  [2] = '{0, 0};
   logic        a_m  [2] = '{1'b0, 1'b0};
   logic [15:0] cnt_m[2] = '{16'd0, 16'd0};
   logic        err_m[2] = '{1'b0, 1'b0};
   logic        qs   [2] = '{1'b0, 1'b0};
   logic        pa   [2] = '{1'b0, 1'b0};
   logic        pen  [2] = '{1'b0, 1'b0};

   latch_en_sequencer #(.WIDTH(1), .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .o_ready(rdy[0]),
      .i_data(dat[0]), .o_a(a[0]), .o_en(en[0]), .i_q(qv[0]), .o_busy(busy[0]),
      .o_err(err[0]), .i_err_clr(clr[0]), .o_cnt(cnt[0]));

   latch_en_sequencer #(.WIDTH(1), .SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .o_ready(rdy[1]),
      .i_data(dat[1]), .o_a(a[1]), .o_en(en[1]), .i_q(qv[1]), .o_busy(busy[1]),
      .o_err(err[1]), .i_err_clr(clr[1]), .o_cnt(cnt[1]));

   // transparent latches on the sequencer outputs, optionally forced to read 0
   always @(en[0] or a[0]) if (en[0]) ql[0] = a[0];
   always @(en[1] or a[1]) if (en[1]) ql[1] = a[1];
   assign qv[0] = fz[0] ? 1'b0 : ql[0];
   assign qv[1] = fz[1] ? 1'b0 : ql[1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic d);
      vld[i] = 1'b1;
      dat[i] = d;
      tick();
      vld[i] = 1'b0;
   endtask

   // hold valid high for n words and check the spacing of acceptances
   task automatic burst(input int i, input int n, input int per, input logic [7:0] pat);
      int   idx;
      int   prev;
      logic hs;
      idx  = 0;
      prev = 0;
      vld[i] = 1'b1;
      dat[i] = pat[0];
      for (int c = 0; c < per * n + 8 && idx < n; c++) begin
         hs = rdy[i];
         tick();
         if (hs) begin
            if (idx > 0) chk("accept_gap", c - prev, per);
            prev = c;
            idx++;
            if (idx < n) dat[i] = pat[idx];
            else vld[i] = 1'b0;
         end
      end
      vld[i] = 1'b0;
      chk("accept_count", idx, n);
   endtask

   // reference model: advances on each edge from the phase count since acceptance
   int mP;
   bit mrdy, mfin;
   initial forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            act_m[i] = 1'b0; t_m[i] = 0; a_m[i] = 1'b0; cnt_m[i] = 16'd0; err_m[i] = 1'b0;
         end else begin
            mP   = SS[i] + OO[i] + HH[i];
            mrdy = !act_m[i] || (t_m[i] == mP - 1);
            mfin = act_m[i] && (t_m[i] == mP - 1);
            err_m[i] = (err_m[i] && !clr[i]) || (mfin && (qs[i] !== a_m[i]));
            if (mfin) cnt_m[i] = cnt_m[i] + 16'd1;
            if (vld[i] && mrdy) begin
               a_m[i] = dat[i]; act_m[i] = 1'b1; t_m[i] = 0;
            end else if (mfin) begin
               act_m[i] = 1'b0;
            end else if (act_m[i]) begin
               t_m[i]++;
            end
         end
      end
   end

   // compare process on the falling edge
   int          cP;
   logic        e_en, e_rdy;
   logic [15:0] e_cnt;
   string       pfx;
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         qs[i] = qv[i];
         if (go) begin
            cP    = SS[i] + OO[i] + HH[i];
            e_en  = act_m[i] && (t_m[i] >= SS[i]) && (t_m[i] < SS[i] + OO[i]);
            e_rdy = !act_m[i] || (t_m[i] == cP - 1);
            e_cnt = cnt_m[i] + base[i];
            pfx   = (i == 0) ? "u0" : "u1";
            chk({pfx, ".o_a"},     a[i],    a_m[i]);
            chk({pfx, ".o_en"},    en[i],   e_en);
            chk({pfx, ".o_ready"}, rdy[i],  e_rdy);
            chk({pfx, ".o_busy"},  busy[i], act_m[i]);
            chk({pfx, ".o_err"},   err[i],  err_m[i]);
            chk({pfx, ".o_cnt"},   cnt[i],  e_cnt);
            if (mon_on && (a[i] !== pa[i]) && (en[i] || pen[i])) viol++;
         end
         pa[i]  = a[i];
         pen[i] = en[i];
      end
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         vld[i] = 1'b0; dat[i] = 1'b0; clr[i] = 1'b0; fz[i] = 1'b0; base[i] = 16'd0;
      end
      // reset asserted mid-cycle, before any clock edge
      #2 rst_n = 1'b0;
      #1;
      go = 1'b1;
      chk("rst_a",    a[0],    0);
      chk("rst_en",   en[0],   0);
      chk("rst_busy", busy[0], 0);
      chk("rst_err",  err[0],  0);
      chk("rst_cnt",  cnt[0],  0);
      chk("rst_rdy",  rdy[0],  1);
      chk("rst_rdy1", rdy[1],  1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // single word on default timing
      send(0, 1'b1);
      chk("w1_a_e0", a[0], 1);
      chk("w1_en_e0", en[0], 0);
      chk("w1_busy_e0", busy[0], 1);
      tick(); chk("w1_en_e1", en[0], 1);
      tick(); tick(); chk("w1_en_e3", en[0], 0);
      chk("w1_a_e3", a[0], 1);
      tick();
      chk("w1_cnt_e4", cnt[0], 1);
      chk("w1_busy_e4", busy[0], 0);
      chk("w1_err_e4", err[0], 0);

      // back-to-back words 1,0,1,1
      burst(0, 4, 4, 8'b0000_1101);
      repeat (4) tick();
      chk("b2b_cnt", cnt[0], 5);
      chk("b2b_busy", busy[0], 0);

      // readback mismatch, clear, and clear coincident with mismatch
      fz[0] = 1'b1;
      send(0, 1'b1);
      repeat (4) tick();
      chk("mis_err", err[0], 1);
      chk("mis_cnt", cnt[0], 6);
      clr[0] = 1'b1; tick(); clr[0] = 1'b0;
      chk("clr_err", err[0], 0);
      send(0, 1'b1);
      repeat (3) tick();
      clr[0] = 1'b1; tick(); clr[0] = 1'b0;
      chk("clr_vs_mis", err[0], 1);
      clr[0] = 1'b1; tick(); clr[0] = 1'b0;
      chk("clr_err2", err[0], 0);
      fz[0] = 1'b0;

      // reset while the gate is open
      mon_on = 1'b0;
      send(0, 1'b1);
      tick();
      chk("open_en", en[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_en",   en[0],   0);
      chk("arst_busy", busy[0], 0);
      chk("arst_a",    a[0],    0);
      chk("arst_cnt",  cnt[0],  0);
      chk("arst_rdy",  rdy[0],  1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      mon_on = 1'b1;
      send(0, 1'b1);
      repeat (4) tick();
      chk("post_rst_cnt", cnt[0], 1);
      chk("post_rst_busy", busy[0], 0);

      // 2/3/2 timing
      send(1, 1'b1);
      chk("t6_en_k0", en[1], 0);
      tick(); chk("t6_en_k1", en[1], 0);
      tick(); chk("t6_en_k2", en[1], 1);
      tick(); tick(); chk("t6_en_k4", en[1], 1);
      tick(); chk("t6_en_k5", en[1], 0);
      tick(); tick();
      chk("t6_cnt_k7", cnt[1], 1);
      chk("t6_busy_k7", busy[1], 0);
      burst(1, 3, 7, 8'b0000_0101);
      repeat (7) tick();
      chk("t6_cnt4", cnt[1], 4);

      // counter wrap: preload near the top, then two transfers
      base[1] = 16'hFFFE - cnt_m[1];
      force u1.cnt_q = 16'hFFFE;
      #1 release u1.cnt_q;
      chk("wrap_preload", cnt[1], 16'hFFFE);
      burst(1, 2, 7, 8'b0000_0011);
      repeat (7) tick();
      chk("wrap_cnt", cnt[1], 0);

      // randomized traffic on both instances
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 2; i++) begin
            vld[i] = 1'($urandom_range(0, 1));
            dat[i] = 1'($urandom_range(0, 1));
            clr[i] = ($urandom_range(0, 15) == 0);
            fz[i]  = ($urandom_range(0, 7) == 0);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         vld[i] = 1'b0; clr[i] = 1'b0; fz[i] = 1'b0;
      end
      repeat (12) tick();
      chk("a_change_while_open", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
